// File: rtl/traffic_conflict_monitor.sv
// Safety monitor for a two-road traffic light: debounces lamp drives, decodes phases,
// latches the first conflict/sequence/timing fault and requests a 1 Hz red flash.
module traffic_conflict_monitor #(
  parameter int CLK_HZ        = 100_000_000,
  parameter int GLITCH_CYCLES = 16,
  parameter int MIN_YELLOW_S  = 2,
  parameter int MAX_GREEN_S   = 15
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic [2:0] roadA_lamps,
  input  logic [2:0] roadB_lamps,
  input  logic       clear_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash_red,
  output logic [1:0] phaseA,
  output logic [1:0] phaseB
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int HW = (CLK_HZ > 3) ? $clog2(CLK_HZ / 2) : 1;
  localparam int GW = $clog2(GLITCH_CYCLES + 1);

  localparam logic [2:0] L_RED = 3'b001;
  localparam logic [2:0] L_GRN = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;

  localparam logic [PW-1:0] P_MAX = PW'(CLK_HZ - 1);
  localparam logic [HW-1:0] H_MAX = HW'(CLK_HZ / 2 - 1);
  localparam logic [GW-1:0] G_MAX = GW'(GLITCH_CYCLES - 1);
  localparam logic [4:0]    T_MINY = 5'(MIN_YELLOW_S);
  localparam logic [4:0]    T_MAXG = 5'(MAX_GREEN_S);

  function automatic logic [1:0] f_phase(input logic [2:0] v);
    case (v)
      L_RED:   f_phase = 2'd0;
      L_GRN:   f_phase = 2'd1;
      L_YEL:   f_phase = 2'd2;
      default: f_phase = 2'd3;
    endcase
  endfunction

  function automatic logic f_multi(input logic [2:0] v);
    f_multi = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  logic [PW-1:0]       r_presc;
  logic [HW-1:0]       r_fcnt;
  logic [1:0][2:0]     r_filt;
  logic [1:0][2:0]     r_last;
  logic [1:0][GW-1:0]  r_gcnt;
  logic [1:0][4:0]     r_tmr;
  logic [1:0][1:0]     r_phase;
  logic                r_fault;
  logic [2:0]          r_code;
  logic                r_flash;

  logic [1:0][2:0] w_raw;
  logic [1:0][2:0] w_nxt;
  logic [1:0]      w_acc;
  logic [1:0]      w_gy;
  logic [1:0]      w_seq;
  logic [1:0]      w_short;
  logic [1:0]      w_stuck;
  logic            w_tick;
  logic            w_conf;
  logic            w_multi;
  logic            w_dark;
  logic            w_lvl;
  logic [2:0]      w_code;

  assign w_raw  = {roadB_lamps, roadA_lamps};
  assign w_tick = (r_presc == P_MAX);

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_acc[i]   = (w_raw[i] != r_filt[i]) && (w_raw[i] == r_last[i]) &&
                   (r_gcnt[i] == G_MAX);
      w_nxt[i]   = w_acc[i] ? w_raw[i] : r_filt[i];
      w_gy[i]    = (r_filt[i] == L_GRN) || (r_filt[i] == L_YEL);
      w_seq[i]   = w_acc[i] &&
                   (((r_filt[i] == L_GRN) && (w_raw[i] == L_RED)) ||
                    ((r_filt[i] == L_YEL) && (w_raw[i] == L_GRN)) ||
                    ((r_filt[i] == L_RED) && (w_raw[i] == L_YEL)));
      w_short[i] = w_acc[i] && (r_filt[i] == L_YEL) &&
                   (w_raw[i] == L_RED) && (r_tmr[i] < T_MINY);
      w_stuck[i] = (r_filt[i] == L_GRN) && (r_tmr[i] > T_MAXG);
    end
    w_conf  = w_gy[0] & w_gy[1];
    w_multi = f_multi(r_filt[0]) | f_multi(r_filt[1]);
    w_dark  = (r_filt[0] == 3'b000) || (r_filt[1] == 3'b000);
    w_lvl   = w_conf | w_multi | w_dark | (|w_stuck);
    // Lowest code wins when several violations coincide
    if (w_conf)         w_code = 3'd1;
    else if (w_multi)   w_code = 3'd2;
    else if (w_dark)    w_code = 3'd3;
    else if (|w_seq)    w_code = 3'd4;
    else if (|w_short)  w_code = 3'd5;
    else if (|w_stuck)  w_code = 3'd6;
    else                w_code = 3'd0;
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_fcnt  <= '0;
      r_filt  <= {L_RED, L_RED};
      r_last  <= {L_RED, L_RED};
      r_gcnt  <= '0;
      r_tmr   <= '0;
      r_phase <= '0;
      r_fault <= 1'b0;
      r_code  <= 3'd0;
      r_flash <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      for (int i = 0; i < 2; i++) begin
        r_last[i] <= w_raw[i];
        // Count restarts on any raw change, so only a steady vector is accepted
        if (w_raw[i] == r_filt[i])      r_gcnt[i] <= '0;
        else if (w_raw[i] != r_last[i]) r_gcnt[i] <= GW'(1);
        else if (w_acc[i])              r_gcnt[i] <= '0;
        else                            r_gcnt[i] <= r_gcnt[i] + 1'b1;
        r_filt[i]  <= w_nxt[i];
        r_phase[i] <= f_phase(w_nxt[i]);
        if (w_acc[i])
          r_tmr[i] <= '0;
        else if (w_tick && (r_tmr[i] != 5'd31))
          r_tmr[i] <= r_tmr[i] + 1'b1;
      end
      if (!r_fault) begin
        if (w_code != 3'd0) begin
          r_fault <= 1'b1;
          r_code  <= w_code;
          r_flash <= 1'b1;
          r_fcnt  <= '0;
        end
      end else if (clear_fault && !w_lvl && (w_code == 3'd0)) begin
        r_fault <= 1'b0;
        r_code  <= 3'd0;
        r_flash <= 1'b0;
        r_fcnt  <= '0;
      end else begin
        if (clear_fault && !w_lvl)
          r_code <= w_code;
        if (r_fcnt == H_MAX) begin
          r_flash <= ~r_flash;
          r_fcnt  <= '0;
        end else begin
          r_fcnt  <= r_fcnt + 1'b1;
        end
      end
    end
  end

  assign fault      = r_fault;
  assign fault_code = r_code;
  assign flash_red  = r_flash;
  assign phaseA     = r_phase[0];
  assign phaseB     = r_phase[1];

endmodule
